// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: data width, FSM state
// type, funct3 access encodings and the access legality check.
package mem_access_unit_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } mem_state_e;

  // Load encodings
  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  // Store encodings
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  // Legal encoding for the direction and naturally aligned for its size.
  function automatic logic access_legal(input logic       is_load,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic f3_ok;
    logic aligned;
    if (is_load) f3_ok = funct3 inside {F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu};
    else         f3_ok = funct3 inside {F3Sb, F3Sh, F3Sw};
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_lo[0];
      default: aligned = (addr_lo == 2'b00);
    endcase
    return f3_ok & aligned;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it according to funct3.
//   rdata_i   : word returned by data memory
//   addr_lo_i : byte offset of the access within the word
//   funct3_i  : load width / signedness
//   ext_o     : extended load result
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] ext_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (addr_lo_i)
      2'd0:    lane_b = rdata_i[7:0];
      2'd1:    lane_b = rdata_i[15:8];
      2'd2:    lane_b = rdata_i[23:16];
      default: lane_b = rdata_i[31:24];
    endcase
    lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3Lb:    ext_o = {{24{lane_b[7]}}, lane_b};
      F3Lh:    ext_o = {{16{lane_h[15]}}, lane_h};
      F3Lbu:   ext_o = {24'h000000, lane_b};
      F3Lhu:   ext_o = {16'h0000, lane_h};
      default: ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit. Turns the EX/MEM load/store request into
// a single held bus request, stalls the pipeline until it is accepted, and
// reports misaligned, illegal or timed-out accesses with a one-cycle error.
//   clk, rst_n          : clock, synchronous active-low reset
//   MEM_*_i             : address, store data, read/write, funct3 from EX/MEM
//   dmem_*_o / dmem_*_i : data memory request side and response side
//   MEM_stall_o         : holds the pipeline while an access is in flight
//   MEM_rd_data_o       : extended load result, held until the next load
//   MEM_done_o/MEM_err_o: completion and error pulses
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic [2:0]            MEM_funct3_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic                  dmem_ready_i,
  output logic                  MEM_stall_o,
  output logic [DATA_WIDTH-1:0] MEM_rd_data_o,
  output logic                  MEM_done_o,
  output logic                  MEM_err_o
);

  localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CntW-1:0] LastWait = CntW'(MAX_WAIT - 1);

  mem_state_e            state_q;
  logic [CntW-1:0]       wait_q;
  logic                  req_q, we_q, err_q, done_q;
  // Set for the cycle after a timeout: the pipeline still presents the
  // failed instruction then and it must be let go, not reissued.
  logic                  retire_q;
  logic                  is_load_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rd_data_q;
  logic [3:0]            be_q;

  logic                  one_req, pending, bad;
  logic [DATA_WIDTH-1:0] wdata_n, load_ext;
  logic [3:0]            be_n;

  always_comb begin
    one_req = MEM_MemRead_i ^ MEM_MemWrite_i;
    pending = one_req & access_legal(MEM_MemRead_i, MEM_funct3_i, MEM_alu_result_i[1:0]);
    bad     = (MEM_MemRead_i & MEM_MemWrite_i) | (one_req & ~pending);

    case (MEM_funct3_i[1:0])
      2'b00: begin
        be_n    = 4'b0001 << MEM_alu_result_i[1:0];
        wdata_n = {4{MEM_wr_data_i[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << MEM_alu_result_i[1:0];
        wdata_n = {2{MEM_wr_data_i[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = MEM_wr_data_i;
      end
    endcase

    MEM_stall_o = rst_n & (((state_q == StIdle) & pending & ~retire_q) | (state_q == StReq));
  end

  load_extend u_load_extend (
    .rdata_i   (dmem_rdata_i),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .ext_o     (load_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      retire_q  <= 1'b0;
      is_load_q <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= 4'b0000;
      rd_data_q <= '0;
    end else begin
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      retire_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (retire_q) begin
            // Timed-out instruction leaves the stage this cycle.
          end else if (pending) begin
            addr_q    <= {MEM_alu_result_i[DATA_WIDTH-1:2], 2'b00};
            addr_lo_q <= MEM_alu_result_i[1:0];
            wdata_q   <= wdata_n;
            be_q      <= be_n;
            we_q      <= MEM_MemWrite_i;
            is_load_q <= MEM_MemRead_i;
            funct3_q  <= MEM_funct3_i;
            req_q     <= 1'b1;
            wait_q    <= '0;
            state_q   <= StReq;
          end else if (bad) begin
            err_q <= 1'b1;
          end
        end
        StReq: begin
          if (dmem_ready_i) begin
            if (is_load_q) rd_data_q <= load_ext;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (wait_q == LastWait) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b1;
            retire_q <= 1'b1;
            state_q  <= StIdle;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dmem_req_o    = req_q;
  assign dmem_we_o     = we_q;
  assign dmem_addr_o   = addr_q;
  assign dmem_wdata_o  = wdata_q;
  assign dmem_be_o     = be_q;
  assign MEM_rd_data_o = rd_data_q;
  assign MEM_done_o    = done_q;
  assign MEM_err_o     = err_q;

endmodule
